fpga_reset_seq: RTL and testbench

FPGA_RESET_SEQ -- requirements
Module: fpga_reset_seq

---
 rtl/fpga_reset_seq.sv | 185 ++++++++++++++++++
 tb/tb_fpga_reset_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_seq.sv
// Power-up reset sequencer: cycles the clock generator until it locks, holds the
// core in reset for a settling period, then watches lock and core-clock activity.
module fpga_reset_seq #(
    parameter int DCM_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int HOLD_CYCLES    = 1024,
    parameter int ACT_WINDOW     = 256,
    parameter int MAX_RETRY      = 7,
    parameter int DEBOUNCE       = 4
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       dcm_locked,
    input  logic       clk1x_mon,
    input  logic [7:0] slideswitch,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic [7:0] switches,
    output logic [1:0] state,
    output logic [3:0] retry_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        DRST  = 2'd0,
        WLOCK = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int MAX_A   = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (HOLD_CYCLES > ACT_WINDOW) ? HOLD_CYCLES : ACT_WINDOW;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0] DRST_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACT_LAST     = CNT_W'(ACT_WINDOW - 1);
    localparam logic [CNT_W-1:0] ACT_SAT      = CNT_W'(ACT_WINDOW);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    // Bit 0 lock, bit 1 core clock monitor, bits 9:2 switches.
    logic [9:0] sync_a, sync_b;
    logic       mon_d;
    logic       lock_s, mon_s, mon_edge;
    logic [7:0] sw_s;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            mon_d  <= 1'b0;
        end else begin
            sync_a <= {slideswitch, clk1x_mon, dcm_locked};
            sync_b <= sync_a;
            mon_d  <= sync_b[1];
        end
    end

    assign lock_s   = sync_b[0];
    assign mon_s    = sync_b[1];
    assign sw_s     = sync_b[9:2];
    assign mon_edge = mon_s ^ mon_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             fault_q, fault_d;
    logic [3:0]       retry_inc;

    assign retry_inc = retry_q + 4'd1;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DRST;
            cnt_q   <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
        end
    end

    // One shared cycle counter, cleared on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        fault_d = fault_q;
        case (state_q)
            DRST: begin
                if (cnt_q == DRST_LAST) begin
                    state_d = WLOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WLOCK: begin
                // Once faulted the sequencer parks here until reset_n.
                if (!fault_q) begin
                    if (lock_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d = DRST;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = DRST;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s || (!mon_edge && cnt_q == ACT_LAST)) begin
                    state_d = DRST;
                    cnt_d   = '0;
                end else if (mon_edge) begin
                    cnt_d = '0;
                end else if (cnt_q != ACT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DRST;
                cnt_d   = '0;
            end
        endcase
    end

    // Decoded straight from the state register so sys_reset reasserts the cycle RUN is left.
    assign dcm_reset   = (state_q == DRST);
    assign sys_reset   = (state_q != RUN);
    assign state       = state_q;
    assign retry_count = retry_q;
    assign fault       = fault_q;

    logic [7:0]      switches_q;
    logic [DB_W-1:0] db_cnt [0:7];

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            switches_q <= '0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sw_s[i] == switches_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    switches_q[i] <= sw_s[i];
                    db_cnt[i]     <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign switches = switches_q;

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Bench for fpga_reset_seq: debounce vector table plus hand-timed sequencer scenarios.
module tb_fpga_reset_seq;

    logic       clk50;
    logic       reset_n;
    logic       dcm_locked;
    logic       clk1x_mon;
    logic [7:0] slideswitch;
    logic       dcm_reset;
    logic       sys_reset;
    logic [7:0] switches;
    logic [1:0] state;
    logic [3:0] retry_count;
    logic       fault;

    fpga_reset_seq #(
        .DCM_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .HOLD_CYCLES   (8),
        .ACT_WINDOW    (6),
        .MAX_RETRY     (3),
        .DEBOUNCE      (2)
    ) dut (
        .clk50      (clk50),
        .reset_n    (reset_n),
        .dcm_locked (dcm_locked),
        .clk1x_mon  (clk1x_mon),
        .slideswitch(slideswitch),
        .dcm_reset  (dcm_reset),
        .sys_reset  (sys_reset),
        .switches   (switches),
        .state      (state),
        .retry_count(retry_count),
        .fault      (fault)
    );

    // Clock and watchdog
    initial begin
        clk50 = 1'b0;
        forever #5 clk50 = ~clk50;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues: status word is {state, dcm_reset, sys_reset, retry_count, fault}
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [7:0] sw_q[$];
    string      sw_name_q[$];

    int mon_ph  = 0;
    bit mon_run = 1'b0;

    // One clock: step past the edge, then advance the core-clock model (toggle every 2 cycles).
    task automatic tick();
        @(posedge clk50);
        #1;
        if (mon_run) begin
            mon_ph = mon_ph + 1;
            if (mon_ph == 2) begin
                clk1x_mon = ~clk1x_mon;
                mon_ph    = 0;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_st(input string nm, input logic [1:0] st, input logic dcm,
                             input logic sys, input logic [3:0] rc, input logic flt);
        exp_q.push_back({st, dcm, sys, rc, flt});
        name_q.push_back(nm);
    endtask

    task automatic compare_st();
        logic [8:0] exp;
        logic [8:0] act;
        string      nm;
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state, dcm_reset, sys_reset, retry_count, fault};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d dcm_reset=%b sys_reset=%b retry=%0d fault=%b, expected state=%0d dcm_reset=%b sys_reset=%b retry=%0d fault=%b",
                     nm, act[8:7], act[6], act[5], act[4:1], act[0],
                     exp[8:7], exp[6], exp[5], exp[4:1], exp[0]);
        end
    endtask

    task automatic check_st(input string nm, input logic [1:0] st, input logic dcm,
                            input logic sys, input logic [3:0] rc, input logic flt);
        expect_st(nm, st, dcm, sys, rc, flt);
        compare_st();
    endtask

    task automatic expect_sw(input string nm, input logic [7:0] v);
        sw_q.push_back(v);
        sw_name_q.push_back(nm);
    endtask

    task automatic compare_sw();
        logic [7:0] exp;
        string      nm;
        exp = sw_q.pop_front();
        nm  = sw_name_q.pop_front();
        checks++;
        if (switches !== exp) begin
            failures++;
            $display("FAIL %s: got switches=%h expected %h", nm, switches, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int budget, input string nm);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (state !== target) begin
            failures++;
            $display("FAIL %s: got state=%0d expected %0d within %0d cycles", nm, state, target, budget);
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous reset values, then releases
    // just after an edge so the next edge is the first one with reset_n high.
    task automatic pulse_reset(input string nm);
        tick();
        reset_n = 1'b0;
        #1;
        check_st(nm, 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        expect_sw({nm, "_sw"}, 8'h00);
        compare_sw();
        ticks(3);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] sw;
        int         hold;
        logic [7:0] exp;
    } db_vec_t;

    db_vec_t db_tbl[11];

    initial begin
        db_tbl[0]  = '{sw: 8'h08, hold: 1, exp: 8'h00};
        db_tbl[1]  = '{sw: 8'h00, hold: 4, exp: 8'h00};  // one-sample glitch rejected
        db_tbl[2]  = '{sw: 8'h08, hold: 3, exp: 8'h00};
        db_tbl[3]  = '{sw: 8'h08, hold: 1, exp: 8'h08};  // sync + 2 samples
        db_tbl[4]  = '{sw: 8'hA5, hold: 4, exp: 8'hA5};
        db_tbl[5]  = '{sw: 8'h5A, hold: 2, exp: 8'hA5};
        db_tbl[6]  = '{sw: 8'hFF, hold: 2, exp: 8'h5A};  // two-sample pulse accepted
        db_tbl[7]  = '{sw: 8'hFF, hold: 4, exp: 8'hFF};
        db_tbl[8]  = '{sw: 8'h00, hold: 4, exp: 8'h00};
        db_tbl[9]  = '{sw: 8'hC3, hold: 3, exp: 8'h00};
        db_tbl[10] = '{sw: 8'hC3, hold: 1, exp: 8'hC3};

        reset_n     = 1'b1;
        dcm_locked  = 1'b0;
        clk1x_mon   = 1'b0;
        slideswitch = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        check_st("por_status", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        expect_sw("por_switches", 8'h00);
        compare_sw();
        ticks(3);
        check_st("por_status_held", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        reset_n = 1'b1;

        // Debounce table
        for (int i = 0; i < 11; i++) begin
            slideswitch = db_tbl[i].sw;
            expect_sw($sformatf("debounce[%0d]", i), db_tbl[i].exp);
            ticks(db_tbl[i].hold);
            compare_sw();
        end

        // Lock never arrives: three attempts then fault
        slideswitch = 8'h00;
        pulse_reset("reset_after_table");
        ticks(23);
        check_st("attempt1_wlock_end", 2'd1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("attempt1_timeout", 2'd0, 1'b1, 1'b1, 4'd1, 1'b0);
        ticks(23);
        check_st("attempt2_wlock_end", 2'd1, 1'b0, 1'b1, 4'd1, 1'b0);
        tick();
        check_st("attempt2_timeout", 2'd0, 1'b1, 1'b1, 4'd2, 1'b0);
        ticks(23);
        check_st("attempt3_wlock_end", 2'd1, 1'b0, 1'b1, 4'd2, 1'b0);
        tick();
        check_st("attempt3_fault", 2'd1, 1'b0, 1'b1, 4'd3, 1'b1);
        ticks(30);
        check_st("fault_sticky", 2'd1, 1'b0, 1'b1, 4'd3, 1'b1);
        dcm_locked = 1'b1;
        ticks(10);
        check_st("fault_ignores_lock", 2'd1, 1'b0, 1'b1, 4'd3, 1'b1);

        // Lock seen on the timeout cycle counts as success
        dcm_locked = 1'b0;
        pulse_reset("reset_clears_fault");
        ticks(21);
        dcm_locked = 1'b1;
        ticks(2);
        check_st("lock_at_timeout_pre", 2'd1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("lock_at_timeout", 2'd2, 1'b0, 1'b1, 4'd0, 1'b0);

        // Normal bring-up: lock 5 cycles into WLOCK, core clock toggling
        dcm_locked  = 1'b0;
        slideswitch = 8'h3C;
        mon_run     = 1'b1;
        pulse_reset("reset_before_bringup");
        ticks(3);
        check_st("drst_last_cycle", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("wlock_entry", 2'd1, 1'b0, 1'b1, 4'd0, 1'b0);
        ticks(4);
        dcm_locked = 1'b1;
        ticks(2);
        check_st("lock_in_sync", 2'd1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("hold_entry", 2'd2, 1'b0, 1'b1, 4'd0, 1'b0);
        ticks(7);
        check_st("hold_last_cycle", 2'd2, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("run_entry", 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        ticks(20);
        check_st("run_with_activity", 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);

        // One-cycle lock drop in RUN
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        tick();
        check_st("lock_drop_in_sync", 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        check_st("lock_drop_to_drst", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        wait_state(2'd3, 40, "rerun_after_lock_drop");
        check_st("rerun_retry_zero", 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);

        // Core clock stops after one last edge
        mon_run = 1'b0;
        tick();
        clk1x_mon = ~clk1x_mon;
        ticks(8);
        check_st("activity_window_edge", 2'd3, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        check_st("activity_timeout", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);

        // Reset during HOLD, then restart and drop lock in HOLD
        mon_run = 1'b1;
        wait_state(2'd2, 40, "reach_hold");
        expect_sw("switches_before_reset", 8'h3C);
        compare_sw();
        pulse_reset("reset_in_hold");
        ticks(3);
        check_st("restart_drst", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("restart_wlock", 2'd1, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("restart_hold", 2'd2, 1'b0, 1'b1, 4'd0, 1'b0);
        dcm_locked = 1'b0;
        ticks(2);
        check_st("hold_lock_drop_sync", 2'd2, 1'b0, 1'b1, 4'd0, 1'b0);
        tick();
        check_st("hold_lock_drop", 2'd0, 1'b1, 1'b1, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
